// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM state encoding and default width shared by
// alu_serial and its digit slice.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // aluop[3] inverts B and forces carry-in; aluop[2:0] selects the function
    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_SLT = 4'b1111;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_NOR: op_is_legal = 1'b1;
            default:                                               op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_digit.sv
// alu_digit: combinational DIGIT-bit ALU slice. B arrives already inverted for
// SUB/SLT. cmsb is the carry into the slice MSB, used for signed overflow.
module alu_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] y,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign cout  = w_sum[DIGIT];
    // carry into the MSB recovered from the MSB sum bit and its operands
    assign cmsb  = a[DIGIT-1] ^ b[DIGIT-1] ^ w_sum[DIGIT-1];

    // function select; SUM and SLT both produce the adder output here
    always_comb begin
        y = '0;
        case (op)
            3'b000:         y = a & b;
            3'b001:         y = a | b;
            3'b010:         y = a ^ b;
            3'b011:         y = ~(a | b);
            3'b110, 3'b111: y = w_sum[DIGIT-1:0];
            default:        y = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, DIGIT bits per RUN cycle, LSB first.
// One operation in flight, valid/ready handshakes on both sides.
// Optional feature: define ALU_SERIAL_OVF_EN to add the ovf output
// (signed overflow for ADD/SUB).
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("alu_serial: DIGIT must divide WIDTH");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_zero;
    logic               r_err;
    logic               r_ovf;

    logic               w_accept;
    logic               w_legal;
    logic               w_last;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT-1:0]   w_y;
    logic               w_cout;
    logic               w_cmsb;
    logic               w_ovf;
    logic               w_slt;
    logic               w_addsub;
    logic [WIDTH-1:0]   w_res_shift;
    logic [WIDTH-1:0]   w_res_next;

    assign w_accept = in_valid & in_ready;
    assign w_legal  = op_is_legal(aluop);
    assign w_last   = (r_cnt == CNT_W'(NDIG - 1));
    assign w_b_dig  = r_b[DIGIT-1:0] ^ {DIGIT{r_op[3]}};

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (w_b_dig),
        .cin  (r_carry),
        .op   (r_op[2:0]),
        .y    (w_y),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // signed overflow and the signed less-than bit, meaningful on the final digit
    assign w_ovf    = w_cmsb ^ w_cout;
    assign w_slt    = w_y[DIGIT-1] ^ w_ovf;
    assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

    generate
        if (NDIG == 1) begin : g_one_digit
            assign w_res_shift = w_y;
        end else begin : g_many_digits
            assign w_res_shift = {w_y, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_res_next = ((r_op == OP_SLT) && w_last) ? {{(WIDTH-1){1'b0}}, w_slt}
                                                     : w_res_shift;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next state: illegal codes skip RUN and report immediately
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_legal ? ST_RUN : ST_DONE;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // operand shift registers, carry and digit counter; contents only matter in RUN
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= aluop;
            r_carry <= aluop[3];
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // result and flags: built digit by digit, frozen once DONE is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_zero <= 1'b0;
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_err <= ~w_legal;
            r_ovf <= 1'b0;
            if (!w_legal) begin
                r_res  <= '0;
                r_zero <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_res <= w_res_next;
            if (w_last) begin
                r_zero <= (w_res_next == '0);
                r_ovf  <= w_addsub & w_ovf;
            end
        end
    end

    assign result = r_res;
    assign zero   = r_zero;
    assign err    = r_err;

`ifdef ALU_SERIAL_OVF_EN
    assign ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized and directed stimulus for alu_serial, checked
// against a plain-arithmetic reference model.
module tb_alu_serial;

    localparam int W   = 32;
    localparam int DG  = 4;
    localparam int LAT = W / DG + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   aluop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;
`ifdef ALU_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_err;
    logic         exp_ovf;
    logic         exp_armed = 1'b0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(W), .DIGIT(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // reference: what the operation means, not how the hardware gets there
    task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic e, output logic v);
        e = 1'b0;
        v = 1'b0;
        case (op)
            4'b0110: begin r = x + y; v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            4'b1110: begin r = x - y; v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
            4'b1111: r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x ^ y;
            4'b0011: r = ~(x | y);
            default: begin r = '0; e = 1'b1; end
        endcase
    endtask

    // whenever a result is presented it must match the model for the last accepted op
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            chk("armed", {31'd0, exp_armed}, 1);
            chk("result", result, exp_res);
            chk("zero", {31'd0, zero}, {31'd0, exp_zero});
            chk("err", {31'd0, err}, {31'd0, exp_err});
`ifdef ALU_SERIAL_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input bit poke);
        logic [W-1:0] r;
        logic         e;
        logic         v;
        logic [W-1:0] held_res;
        logic         held_zero;
        logic         held_err;
        int           lat;
        model(op, x, y, r, e, v);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 1);
        exp_res   = r;
        exp_zero  = (r == '0);
        exp_err   = e;
        exp_ovf   = v;
        exp_armed = 1'b1;
        in_valid  = 1'b1;
        aluop     = op;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (poke && lat == 3) begin
                chk("in_ready_busy", {31'd0, in_ready}, 0);
                in_valid = 1'b1;
                aluop    = 4'b0001;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, e ? 1 : LAT);
        held_res  = result;
        held_zero = zero;
        held_err  = err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_in_ready", {31'd0, in_ready}, 0);
            chk("hold_result", result, held_res);
            chk("hold_flags", {30'd0, zero, err}, {30'd0, held_zero, held_err});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_armed = 1'b0;
        chk("released_valid", {31'd0, out_valid}, 0);
        chk("released_in_ready", {31'd0, in_ready}, 1);
    endtask

    logic [3:0]   legal_ops [7] = '{4'b0110, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011};
    logic [W-1:0] specials  [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h1234_5678};

    function automatic logic [W-1:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r;
        logic         e;
        logic         v;
        logic [3:0]   op;
        logic [W-1:0] x;

        // the model itself against hand-computed values
        model(4'b0110, 32'h5, 32'h3, r, e, v);                chk("model_add", r, 32'h8);
        model(4'b1110, 32'h0, 32'h1, r, e, v);                chk("model_sub", r, 32'hFFFF_FFFF);
        model(4'b1111, 32'hFFFF_FFFF, 32'h1, r, e, v);        chk("model_slt_neg", r, 32'h1);
        model(4'b1111, 32'h7FFF_FFFF, 32'h8000_0000, r, e, v); chk("model_slt_ovf", r, 32'h0);
        model(4'b0011, 32'h0, 32'h0, r, e, v);                chk("model_nor", r, 32'hFFFF_FFFF);
        model(4'b0101, 32'h9, 32'h9, r, e, v);                chk("model_illegal", {31'd0, e}, 1);
        model(4'b0110, 32'h7FFF_FFFF, 32'h1, r, e, v);        chk("model_add_ovf", {31'd0, v}, 1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = 4'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {30'd0, zero, err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        // directed vectors
        run_op(4'b0110, 32'h5, 32'h3, 0, 0);
        run_op(4'b1110, 32'h1234_5678, 32'h1234_5678, 0, 0);
        run_op(4'b1110, 32'h0, 32'h1, 0, 0);
        run_op(4'b1111, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op(4'b1111, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
        run_op(4'b0011, 32'h0, 32'h0, 0, 0);
        run_op(4'b0101, 32'hDEAD_BEEF, 32'h1, 2, 0);
        run_op(4'b0110, 32'h7FFF_FFFF, 32'h1, 5, 1);
        run_op(4'b1110, 32'h8000_0000, 32'h1, 1, 0);

        // reset while RUN: leave a zero=1 result behind first so the clear is visible
        run_op(4'b1110, 32'h55, 32'h55, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        aluop    = 4'b0110;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", {31'd0, out_valid}, 0);
        chk("midrun_rst_result", result, 0);
        chk("midrun_rst_flags", {30'd0, zero, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0010, 32'hF0F0_1234, 32'h0FF0_4321, 0, 0);

        // random traffic, mostly legal codes, occasional arbitrary ones
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
            x  = pick_operand();
            if ($urandom_range(0, 7) == 0) run_op(op, x, x, $urandom_range(0, 3), 1'($urandom));
            else run_op(op, x, pick_operand(), $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
